// File: rtl/mant_mul_pkg.sv
// mant_mul_pkg
//   Shared types and helpers for the sequential mantissa multiplier.
//   - mul_state_t       : FSM state encoding (IDLE, RUN, DONE)
//   - MUL_WIDTH_DEFAULT : default operand width in bits
//   - cnt_w()           : width of the step counter for a given operand width
package mant_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  localparam int MUL_WIDTH_DEFAULT = 8;

  // The counter has to hold the value WIDTH, hence width+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mant_mul_seq_acc_add.sv
// mul_acc_add
//   Combinational accumulate adder for the shift-and-add multiplier.
//   Kept as its own block so a prefix adder can be dropped in later.
//   Ports:
//     acc_i   [SUM_W-1:0] current accumulator
//     mcand_i [SUM_W-1:0] shifted multiplicand
//     en_i                add mcand_i when high, pass acc_i through when low
//     sum_o   [SUM_W-1:0] acc_i + (en_i ? mcand_i : 0)
//     carry_o             carry out of the SUM_W-bit add
module mul_acc_add #(
  parameter int SUM_W = 16
) (
  input  logic [SUM_W-1:0] acc_i,
  input  logic [SUM_W-1:0] mcand_i,
  input  logic             en_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             carry_o
);

  logic [SUM_W-1:0] addend;

  assign addend = en_i ? mcand_i : '0;

  // One extra bit on each side exposes the carry-out.
  assign {carry_o, sum_o} = {1'b0, acc_i} + {1'b0, addend};

endmodule

// File: rtl/mant_mul_seq.sv
// mant_mul_seq
//   Sequential shift-and-add unsigned mantissa multiplier. It accepts one
//   operand pair at a time, runs exactly WIDTH steps and then holds the
//   2*WIDTH-bit product until the downstream stage takes it.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     in_valid  operand pair valid            in_ready  block can accept a pair
//     in_a      multiplicand [WIDTH-1:0]      in_b      multiplier [WIDTH-1:0]
//     out_valid out_prod holds a product      out_ready downstream accepts it
//     out_prod  product [2*WIDTH-1:0]         busy      state is not IDLE
//   Every output is driven straight from a register.
module mant_mul_seq
  import mant_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 busy
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t        state_q;
  logic [PROD_W-1:0] mcand_q;
  logic [WIDTH-1:0]  mplr_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] out_prod_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              add_carry;

  // acc_d is the accumulator after the current step; the low multiplier
  // bit decides whether this step adds the shifted multiplicand.
  mul_acc_add #(
    .SUM_W (PROD_W)
  ) u_acc_add (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .en_i    (mplr_q[0]),
    .sum_o   (acc_d),
    .carry_o (add_carry)
  );

  // Whole FSM plus registered outputs. in_ready_q and busy_q are loaded
  // with the value implied by the state being entered, so they line up
  // with state_q on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_prod_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= {{WIDTH{1'b0}}, in_a};
            mplr_q     <= in_b;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Last step: publish the accumulator including this step's add.
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_prod_q  <= acc_d;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign busy      = busy_q;

  // The product of two WIDTH-bit values fits in 2*WIDTH bits, so the
  // accumulate adder must never carry out.
  a_no_carry : assert property (@(posedge clk) disable iff (!rst_n) (add_carry == 1'b0));

endmodule

// File: tb/tb_mant_mul_seq.sv
// tb_mant_mul_seq
//   Directed and random checks for mant_mul_seq with WIDTH = 8.
module tb_mant_mul_seq;

  localparam int W = 8;
  localparam int N_STRESS = 2000;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  mant_mul_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until in_ready, then present one operand pair for a single edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      total_cnt++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_result(output logic [2*W-1:0] prod, output int cyc);
    cyc = 0;
    prod = '0;
    while (cyc < 20) begin
      step();
      cyc++;
      if (out_valid === 1'b1) break;
    end
    if (out_valid !== 1'b1) begin
      total_cnt++;
      $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
    end
    prod = out_prod;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h12;
    in_b = 8'h34;
    out_ready = 1'b1;
    repeat (3) step();
    total_cnt++;
    if ({out_valid, in_ready, busy} !== 3'b000)
      $display("[TB] FAIL reset_flags: got v/r/b=%b required 000", {out_valid, in_ready, busy});
    else pass_cnt++;
    total_cnt++;
    if (out_prod !== 16'h0000)
      $display("[TB] FAIL reset_prod: got %h required 0000", out_prod);
    else pass_cnt++;

    rst_n = 1'b1;
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("[TB] FAIL ready_before_edge: got %b required 0", in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL ready_after_release: got %b required 1", in_ready);
    else pass_cnt++;

    // Asynchronous assertion in the middle of a cycle, no clock edge.
    start_op(8'h12, 8'h34);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, busy} !== 3'b000)
      $display("[TB] FAIL async_reset: got v/r/b=%b required 000", {out_valid, in_ready, busy});
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL ready_after_async: got %b required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_scale();
    logic [2*W-1:0] prod;
    int cyc;
    out_ready = 1'b1;
    start_op(8'hFF, 8'hFF);
    total_cnt++;
    if ({busy, in_ready} !== 2'b10)
      $display("[TB] FAIL busy_after_accept: got busy/ready=%b required 10", {busy, in_ready});
    else pass_cnt++;
    wait_result(prod, cyc);
    total_cnt++;
    if (cyc !== 8) $display("[TB] FAIL latency_ff: got %0d required 8", cyc);
    else pass_cnt++;
    total_cnt++;
    if (prod !== 16'hFE01) $display("[TB] FAIL prod_ff: got %h required fe01", prod);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("[TB] FAIL after_handshake: got v/r/b=%b required 010", {out_valid, in_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_edge_operands();
    logic [W-1:0]   va [3] = '{8'h80, 8'h00, 8'h01};
    logic [W-1:0]   vb [3] = '{8'h02, 8'hAB, 8'h01};
    logic [2*W-1:0] vp [3] = '{16'h0100, 16'h0000, 16'h0001};
    logic [2*W-1:0] prod;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_result(prod, cyc);
      total_cnt++;
      if (cyc !== 8) $display("[TB] FAIL latency_edge%0d: got %0d required 8", i, cyc);
      else pass_cnt++;
      total_cnt++;
      if (prod !== vp[i]) $display("[TB] FAIL prod_edge%0d: got %h required %h", i, prod, vp[i]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] prod;
    int cyc;
    out_ready = 1'b0;
    start_op(8'h0F, 8'h11);
    wait_result(prod, cyc);
    total_cnt++;
    if (prod !== 16'h00FF) $display("[TB] FAIL prod_bp: got %h required 00ff", prod);
    else pass_cnt++;
    // Offer a different pair while the result is held; it must be ignored.
    in_valid = 1'b1;
    in_a = 8'hFF;
    in_b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if ({out_valid, in_ready, busy, out_prod} !== {3'b101, 16'h00FF})
        $display("[TB] FAIL hold_bp%0d: got v/r/b=%b prod=%h required 101 00ff",
                 i, {out_valid, in_ready, busy}, out_prod);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({out_valid, in_ready, out_prod} !== {2'b01, 16'h00FF})
      $display("[TB] FAIL release_bp: got v/r=%b prod=%h required 01 00ff",
               {out_valid, in_ready}, out_prod);
    else pass_cnt++;
    start_op(8'h12, 8'h34);
    wait_result(prod, cyc);
    total_cnt++;
    if (prod !== 16'h03A8) $display("[TB] FAIL prod_after_bp: got %h required 03a8", prod);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] prod;
    int cyc;
    bit seen;
    out_ready = 1'b1;
    start_op(8'hAA, 8'h55);
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, busy} !== 2'b00)
      $display("[TB] FAIL mid_run_reset: got v/b=%b required 00", {out_valid, busy});
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("[TB] FAIL aborted_valid: got %b required 0", seen);
    else pass_cnt++;
    start_op(8'h03, 8'h05);
    wait_result(prod, cyc);
    total_cnt++;
    if (prod !== 16'h000F) $display("[TB] FAIL prod_after_abort: got %h required 000f", prod);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random_stress();
    logic [2*W-1:0] exp_q [$];
    int rcv;
    int cyc;
    rcv = 0;
    cyc = 0;
    fork
      begin : driver
        logic [W-1:0] a;
        logic [W-1:0] b;
        int guard;
        for (int i = 0; i < N_STRESS; i++) begin
          a = W'($urandom);
          b = W'($urandom);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) step();
          guard = 0;
          // Junk traffic while busy must be ignored.
          while (in_ready !== 1'b1 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = W'($urandom);
            in_b = W'($urandom);
            step();
            guard++;
          end
          if (guard >= 200) begin
            total_cnt++;
            $display("[TB] FAIL stress_accept_timeout: op %0d never accepted", i);
            break;
          end
          in_a = a;
          in_b = b;
          in_valid = 1'b1;
          exp_q.push_back((2*W)'(a) * (2*W)'(b));
          step();
          in_valid = 1'b0;
        end
      end
      begin : monitor
        logic [2*W-1:0] e;
        while (rcv < N_STRESS && cyc < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
              $display("[TB] FAIL stress_dup: got prod=%h required no result", out_prod);
            end else begin
              e = exp_q.pop_front();
              if (out_prod !== e)
                $display("[TB] FAIL stress_prod%0d: got %h required %h", rcv, out_prod, e);
              else pass_cnt++;
            end
            rcv++;
          end
          step();
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    total_cnt++;
    if (rcv !== N_STRESS) $display("[TB] FAIL stress_count: got %0d required %0d", rcv, N_STRESS);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("[TB] FAIL stress_leftover: got %0d required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_edge_operands();
    test_backpressure();
    test_reset_mid_run();
    test_random_stress();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
